// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one fixed-latency single-port RAM between IF and MEM with an IF starvation guard
module imem_dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifRdata,
  output logic              ifAck,
  input  logic              memReq,
  input  logic              memWe,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memWdata,
  output logic [DATA_W-1:0] memRdata,
  output logic              memAck,
  output logic              stallIF,
  output logic              stallMEM,
  output logic              ramEn,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata
);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state;
  logic owner_mem, we_q, grant_mem;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  assign grant_mem = memReq & ~(ifReq & (starve_cnt == SW'(STARVE_MAX)));
  assign stallIF = ifReq & ~ifAck;
  assign stallMEM = memReq & ~memAck;
  // access sequencer: grant in IDLE, strobe RAM once, count out latency, pulse owner's ack
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner_mem <= 1'b0;
      we_q <= 1'b0;
      lat_cnt <= '0;
      starve_cnt <= '0;
      ramEn <= 1'b0;
      ramWe <= 1'b0;
      ramAddr <= '0;
      ramWdata <= '0;
      ifAck <= 1'b0;
      memAck <= 1'b0;
      ifRdata <= '0;
      memRdata <= '0;
    end else begin
      ramEn <= 1'b0;
      ramWe <= 1'b0;
      ifAck <= 1'b0;
      memAck <= 1'b0;
      case (state)
        IDLE: if (ifReq | memReq) begin
          state <= ISSUE;
          owner_mem <= grant_mem;
          we_q <= grant_mem & memWe;
          ramEn <= 1'b1;
          ramWe <= grant_mem & memWe;
          ramAddr <= grant_mem ? memAddr : ifAddr;
          ramWdata <= grant_mem ? memWdata : ramWdata;
          starve_cnt <= !grant_mem ? '0 :
                        (ifReq && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
        end
        ISSUE: begin
          state <= WAIT;
          lat_cnt <= LW'(MEM_LAT);
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LW'(1)) begin
            state <= ACK;
            ifAck <= ~owner_mem;
            memAck <= owner_mem;
            ifRdata <= owner_mem ? ifRdata : ramRdata;
            memRdata <= (owner_mem && !we_q) ? ramRdata : memRdata;
          end
        end
        ACK: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed and randomized checks of the IF/MEM RAM arbiter against a transaction-level model
module tb_imem_dmem_arbiter;
  localparam int L = 2;
  localparam int SM = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ifReq = 1'b0, memReq = 1'b0, memWe = 1'b0;
  logic [31:0] ifAddr = '0, memAddr = '0, memWdata = '0;
  logic [31:0] ifRdata, memRdata, ramAddr, ramWdata, ramRdata;
  logic ifAck, memAck, stallIF, stallMEM, ramEn, ramWe;
  int total = 0, bad = 0;
  bit [31:0] ram [1024];
  bit ram_v [1024];
  bit [31:0] ref_mem [1024];
  bit ref_valid [1024];
  int rd_cnt = 0;
  logic [31:0] rd_addr = '0;

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset_n(reset_n),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifAck(ifAck),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck), .stallIF(stallIF), .stallMEM(stallMEM),
    .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWdata(ramWdata), .ramRdata(ramRdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C080004 : (a * 32'h01000193) ^ 32'h12345678;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return ref_valid[a[11:2]] ? ref_mem[a[11:2]] : init_val(a);
  endfunction

  // RAM: data is valid only in the cycle MEM_LAT cycles after the enable cycle
  always @(posedge clock) begin
    if (ramEn) begin
      rd_cnt <= L;
      rd_addr <= ramAddr;
      if (ramWe) begin
        ram[ramAddr[11:2]] <= ramWdata;
        ram_v[ramAddr[11:2]] <= 1'b1;
      end
    end else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
  end
  assign ramRdata = (rd_cnt == 1) ? (ram_v[rd_addr[11:2]] ? ram[rd_addr[11:2]] : init_val(rd_addr)) : 32'hBAD0BAD0;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic test_reset();
    @(posedge clock); #1;
    total++;
    if ({ramEn, ramWe, ifAck, memAck, stallIF, stallMEM} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000", {ramEn, ramWe, ifAck, memAck, stallIF, stallMEM});
    end
    total++;
    if ({ramAddr, ramWdata, ifRdata, memRdata} !== 128'b0) begin
      bad++; $display("FAIL reset_data got=%h %h %h %h exp=0", ramAddr, ramWdata, ifRdata, memRdata);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_if_fetch();
    ifAddr = 32'h40; ifReq = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      total++;
      if (ramEn !== (k == 1)) begin bad++; $display("FAIL fetch_ramEn k=%0d got=%b exp=%b", k, ramEn, k == 1); end
      if (k == 1) begin
        total++;
        if (ramAddr !== 32'h40 || ramWe !== 1'b0) begin bad++; $display("FAIL fetch_addr got=%h we=%b exp=40 we=0", ramAddr, ramWe); end
      end
      total++;
      if (ifAck !== (k == L + 2)) begin bad++; $display("FAIL fetch_ack k=%0d got=%b exp=%b", k, ifAck, k == L + 2); end
      if (k == L + 2) begin
        total++;
        if (ifRdata !== 32'h8C080004) begin bad++; $display("FAIL fetch_data got=%h exp=8c080004", ifRdata); end
      end
      total++;
      if (stallIF !== (k < L + 2)) begin bad++; $display("FAIL fetch_stall k=%0d got=%b exp=%b", k, stallIF, k < L + 2); end
      @(posedge clock); #1;
      if (k == L + 2) ifReq = 1'b0;
    end
  endtask

  task automatic test_both();
    int a1, a2;
    a1 = L + 2; a2 = 2 * L + 5;
    ifAddr = 32'h80; memAddr = 32'h100; memWe = 1'b0; ifReq = 1'b1; memReq = 1'b1;
    for (int k = 0; k <= a2 + 2; k++) begin
      @(negedge clock);
      total++;
      if (ramEn !== (k == 1 || k == L + 4)) begin bad++; $display("FAIL both_ramEn k=%0d got=%b", k, ramEn); end
      if (k == 1 || k == L + 4) begin
        total++;
        if (ramAddr !== ((k == 1) ? 32'h100 : 32'h80)) begin bad++; $display("FAIL both_addr k=%0d got=%h", k, ramAddr); end
      end
      total++;
      if (memAck !== (k == a1) || ifAck !== (k == a2)) begin
        bad++; $display("FAIL both_acks k=%0d got mem=%b if=%b exp mem=%b if=%b", k, memAck, ifAck, k == a1, k == a2);
      end
      if (k == a1) begin
        total++;
        if (memRdata !== exp_word(32'h100)) begin bad++; $display("FAIL both_mdata got=%h exp=%h", memRdata, exp_word(32'h100)); end
      end
      if (k == a2) begin
        total++;
        if (ifRdata !== exp_word(32'h80)) begin bad++; $display("FAIL both_idata got=%h exp=%h", ifRdata, exp_word(32'h80)); end
      end
      total++;
      if (stallIF !== (k < a2)) begin bad++; $display("FAIL both_stall k=%0d got=%b exp=%b", k, stallIF, k < a2); end
      @(posedge clock); #1;
      if (k == a1) memReq = 1'b0;
      if (k == a2) ifReq = 1'b0;
    end
  endtask

  task automatic test_starve();
    int g = 0;
    bit done = 1'b0;
    ifAddr = 32'hC0; memAddr = 32'h300; memWe = 1'b0; ifReq = 1'b1; memReq = 1'b1;
    for (int k = 0; k < 120 && !done; k++) begin
      @(negedge clock);
      if (ramEn) begin
        total++;
        if ((ramAddr == 32'hC0) !== (g % 5 == 4)) begin
          bad++; $display("FAIL starve_grant g=%0d got_if=%b exp_if=%b", g, ramAddr == 32'hC0, g % 5 == 4);
        end
        g++;
      end
      done = (g == 10) && ifAck;
      @(posedge clock); #1;
    end
    ifReq = 1'b0; memReq = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL starve_count got=%0d exp=10", g); end
  endtask

  task automatic test_write();
    logic [31:0] prior;
    prior = exp_word(32'h300);
    memWe = 1'b1; memAddr = 32'h200; memWdata = 32'hDEADBEEF; memReq = 1'b1;
    for (int k = 0; k < L + 4; k++) begin
      @(negedge clock);
      total++;
      if (ramEn !== (k == 1) || ramWe !== (k == 1)) begin bad++; $display("FAIL wr_strobe k=%0d got en=%b we=%b", k, ramEn, ramWe); end
      if (k == 1) begin
        total++;
        if (ramAddr !== 32'h200 || ramWdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_bus got=%h %h exp=200 deadbeef", ramAddr, ramWdata); end
      end
      total++;
      if (memAck !== (k == L + 2)) begin bad++; $display("FAIL wr_ack k=%0d got=%b", k, memAck); end
      total++;
      if (memRdata !== prior) begin bad++; $display("FAIL wr_rdata_hold got=%h exp=%h", memRdata, prior); end
      @(posedge clock); #1;
      if (k == L + 2) memReq = 1'b0;
    end
    ref_mem[32'h200 >> 2] = 32'hDEADBEEF; ref_valid[32'h200 >> 2] = 1'b1;
    memWe = 1'b0; memReq = 1'b1;
    for (int k = 0; k < L + 4; k++) begin
      @(negedge clock);
      total++;
      if (memAck !== (k == L + 2)) begin bad++; $display("FAIL rd_ack k=%0d got=%b", k, memAck); end
      if (k == L + 2) begin
        total++;
        if (memRdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", memRdata); end
      end
      @(posedge clock); #1;
      if (k == L + 2) memReq = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    ifAddr = 32'h44; ifReq = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({ramEn, ifAck, memAck} !== 3'b0 || ifRdata !== 32'h0 || memRdata !== 32'h0 || ramAddr !== 32'h0) begin
      bad++; $display("FAIL rstmid_clear got en=%b ia=%b ma=%b ird=%h mrd=%h addr=%h", ramEn, ifAck, memAck, ifRdata, memRdata, ramAddr);
    end
    ifReq = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      total++;
      if ({ramEn, ifAck, memAck} !== 3'b0) begin bad++; $display("FAIL rstmid_quiet k=%0d got=%b", k, {ramEn, ifAck, memAck}); end
      @(posedge clock); #1;
    end
    ifAddr = 32'h48; ifReq = 1'b1;
    for (int k = 0; k < L + 4; k++) begin
      @(negedge clock);
      total++;
      if (ifAck !== (k == L + 2)) begin bad++; $display("FAIL rstmid_ack k=%0d got=%b", k, ifAck); end
      if (k == L + 2) begin
        total++;
        if (ifRdata !== exp_word(32'h48)) begin bad++; $display("FAIL rstmid_data got=%h exp=%h", ifRdata, exp_word(32'h48)); end
      end
      @(posedge clock); #1;
      if (k == L + 2) ifReq = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    a1 = L + 2; a2 = 2 * L + 5;
    ifAddr = 32'h0; ifReq = 1'b1;
    for (int k = 0; k <= a2 + 2; k++) begin
      @(negedge clock);
      total++;
      if (ramEn !== (k == 1 || k == L + 4)) begin bad++; $display("FAIL b2b_ramEn k=%0d got=%b", k, ramEn); end
      if (k == 1 || k == L + 4) begin
        total++;
        if (ramAddr !== ((k == 1) ? 32'h0 : 32'h4)) begin bad++; $display("FAIL b2b_addr k=%0d got=%h", k, ramAddr); end
      end
      total++;
      if (ifAck !== (k == a1 || k == a2)) begin bad++; $display("FAIL b2b_ack k=%0d got=%b", k, ifAck); end
      if (k == a1 || k == a2) begin
        total++;
        if (ifRdata !== exp_word((k == a1) ? 32'h0 : 32'h4)) begin bad++; $display("FAIL b2b_data k=%0d got=%h", k, ifRdata); end
      end
      @(posedge clock); #1;
      if (k == a1) ifAddr = 32'h4;
      if (k == a2) ifReq = 1'b0;
    end
  endtask

  task automatic test_random();
    bit pi = 0, pm = 0, pw = 0, pidle = 1, inf = 0, own_m = 0, own_w = 0, eif, emem, en;
    logic [31:0] pia = '0, pma = '0, pwd = '0, a, exp_d = '0, lir, lmr;
    int due = 0, starve = 0;
    lir = exp_word(32'h4); lmr = '0;
    for (int k = 0; k < 450; k++) begin
      @(negedge clock);
      en = pidle && (pi || pm);
      total++;
      if (ramEn !== en) begin bad++; $display("FAIL rnd_ramEn k=%0d got=%b exp=%b", k, ramEn, en); end
      if (en) begin
        own_m = pm && !(pi && starve == SM);
        starve = own_m ? ((pi && starve < SM) ? starve + 1 : starve) : 0;
        own_w = own_m && pw;
        a = own_m ? pma : pia;
        total++;
        if (ramAddr !== a || ramWe !== own_w) begin bad++; $display("FAIL rnd_issue k=%0d got=%h/%b exp=%h/%b", k, ramAddr, ramWe, a, own_w); end
        if (own_w) begin
          total++;
          if (ramWdata !== pwd) begin bad++; $display("FAIL rnd_wdata k=%0d got=%h exp=%h", k, ramWdata, pwd); end
          ref_mem[a[11:2]] = pwd; ref_valid[a[11:2]] = 1'b1;
        end else exp_d = exp_word(a);
        inf = 1'b1; due = k + L + 1;
      end
      eif = inf && k == due && !own_m;
      emem = inf && k == due && own_m;
      total++;
      if (ifAck !== eif || memAck !== emem) begin bad++; $display("FAIL rnd_ack k=%0d got=%b%b exp=%b%b", k, ifAck, memAck, eif, emem); end
      if (eif) lir = exp_d;
      if (emem && !own_w) lmr = exp_d;
      total++;
      if (ifRdata !== lir || memRdata !== lmr) begin bad++; $display("FAIL rnd_rdata k=%0d got=%h/%h exp=%h/%h", k, ifRdata, memRdata, lir, lmr); end
      total++;
      if (stallIF !== (ifReq && !eif) || stallMEM !== (memReq && !emem)) begin bad++; $display("FAIL rnd_stall k=%0d got=%b%b", k, stallIF, stallMEM); end
      pidle = !inf;
      if (eif || emem) inf = 1'b0;
      pi = ifReq; pm = memReq; pia = ifAddr; pma = memAddr; pw = memWe; pwd = memWdata;
      @(posedge clock); #1;
      if (eif || !ifReq) begin
        ifReq = (k < 400) && ($urandom_range(0, 2) == 0);
        ifAddr = 32'($urandom_range(0, 15)) << 2;
      end
      if (emem || !memReq) begin
        memReq = (k < 400) && ($urandom_range(0, 2) == 0);
        memAddr = 32'($urandom_range(0, 15)) << 2;
        memWe = 1'($urandom_range(0, 1));
        memWdata = $urandom;
      end
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_both();
    test_starve();
    test_write();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
